pipe_skid_reg: RTL

- Parametrised elastic pipeline-stage register: the successor to the fixed inter-stage latches between decode/execute/memory.
- Carries a control bundle and a data bundle with a valid/ready handshake.
- Includes a one-entry skid buffer, so back-pressure never creates a combinational ready path.
- Supports a synchronous flush that inserts bubbles: control is forced to a safe value and valid is cleared.

---
 rtl/pipe_skid_reg.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic pipeline-stage register with a one-entry skid buffer.
// Carries a control bundle and a data bundle between pipeline stages using a
// valid/ready handshake. Every output, including in_ready_o, comes straight
// from a flop, so back-pressure never forms a combinational path from
// out_ready_i to in_ready_o.
//
// The main register always drives the outputs. The skid register catches the
// one beat that upstream may push in during the cycle when the downstream
// stalls. That beat is accepted because in_ready_o was still high from the
// previous cycle.
//
// A synchronous flush drops every held beat and returns the stage to empty.
// While the stage is empty, out_ctrl_o shows the bubble encoding CTRL_RST, so
// later stages see a harmless control word.

module pipe_skid_reg #(
   parameter int unsigned       CTRL_W   = 8,
   parameter int unsigned       DATA_W   = 128,
   parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}}
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occupancy_o
);

   // EMPTY holds nothing, FULL holds one beat in the main register, and SKID
   // holds a second beat parked in the skid register behind the main one.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } stageState_e;

   stageState_e       state_q;
   logic              inReady_q;
   logic              outValid_q;
   logic [CTRL_W-1:0] mainCtrl_q;
   logic [DATA_W-1:0] mainData_q;
   logic [CTRL_W-1:0] skidCtrl_q;
   logic [DATA_W-1:0] skidData_q;
   logic [1:0]        occupancy_q;

   logic              accept;
   logic              fire;

   // Handshake events seen at the coming edge. Both use only registered
   // readiness and validity, so no input ever reaches an output without a flop.
   always_comb begin
      accept = in_valid_i & inReady_q;
      fire   = outValid_q & out_ready_i;
   end

   // Stage controller. The state, the handshake flags, the occupancy count and
   // both payload registers all update here, so every output is registered.
   // Flush has priority over any handshake in the same cycle. A beat accepted
   // in that cycle is dropped, and a beat fired in that cycle counts as
   // consumed.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= EMPTY;
         inReady_q   <= 1'b1;
         outValid_q  <= 1'b0;
         mainCtrl_q  <= CTRL_RST;
         mainData_q  <= '0;
         skidCtrl_q  <= '0;
         skidData_q  <= '0;
         occupancy_q <= 2'd0;
      end else if (flush_i) begin
         state_q     <= EMPTY;
         inReady_q   <= 1'b1;
         outValid_q  <= 1'b0;
         mainCtrl_q  <= CTRL_RST;
         occupancy_q <= 2'd0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_q     <= FULL;
                  outValid_q  <= 1'b1;
                  mainCtrl_q  <= in_ctrl_i;
                  mainData_q  <= in_data_i;
                  occupancy_q <= 2'd1;
               end
            end

            FULL: begin
               if (fire && accept) begin
                  mainCtrl_q <= in_ctrl_i;
                  mainData_q <= in_data_i;
               end else if (fire) begin
                  state_q     <= EMPTY;
                  outValid_q  <= 1'b0;
                  mainCtrl_q  <= CTRL_RST;
                  occupancy_q <= 2'd0;
               end else if (accept) begin
                  state_q     <= SKID;
                  inReady_q   <= 1'b0;
                  skidCtrl_q  <= in_ctrl_i;
                  skidData_q  <= in_data_i;
                  occupancy_q <= 2'd2;
               end
            end

            SKID: begin
               if (fire) begin
                  state_q     <= FULL;
                  inReady_q   <= 1'b1;
                  mainCtrl_q  <= skidCtrl_q;
                  mainData_q  <= skidData_q;
                  occupancy_q <= 2'd1;
               end
            end

            default: begin
               state_q     <= EMPTY;
               inReady_q   <= 1'b1;
               outValid_q  <= 1'b0;
               mainCtrl_q  <= CTRL_RST;
               occupancy_q <= 2'd0;
            end
         endcase
      end
   end

   // Outputs come straight from the registers above.
   always_comb begin
      in_ready_o  = inReady_q;
      out_valid_o = outValid_q;
      out_ctrl_o  = mainCtrl_q;
      out_data_o  = mainData_q;
      occupancy_o = occupancy_q;
   end

endmodule
